// File: rtl/nes_poll_scheduler.sv
// Periodic poll scheduler for the NES controller reader: issues read requests at a fixed rate,
// supervises each transaction with a timeout, and debounces samples into a stable button vector.
module nes_poll_scheduler #(
  parameter int unsigned CYCLES_PER_POLL = 416667,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned STABLE_POLLS    = 2
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_enable,
  output logic       o_read_buttons,
  input  logic       i_valid,
  input  logic [7:0] i_buttons,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_update,
  output logic       o_timeout,
  output logic       o_overrun
);

  localparam int unsigned PW = $clog2(CYCLES_PER_POLL);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(STABLE_POLLS + 1);

  localparam logic [PW-1:0] PeriodLast = PW'(CYCLES_PER_POLL - 1);
  localparam logic [TW-1:0] TmoLast    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] StableMax  = SW'(STABLE_POLLS);

  typedef enum logic [0:0] {StWait, StBusy} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    buttons_q, buttons_d;
  logic [7:0]    pressed_q, pressed_d;
  logic [7:0]    released_q, released_d;
  logic          read_q, read_d;
  logic          update_q, update_d;
  logic          timeout_q, timeout_d;
  logic          overrun_q, overrun_d;

  logic          tick;
  logic          capture;
  logic          abandon;
  logic [SW-1:0] stable_inc;

  // Period counter is free-running while enabled, independent of the transaction FSM.
  always_comb begin
    tick = i_enable && (period_q == PeriodLast);
    if (!i_enable || tick) begin
      period_d = '0;
    end else begin
      period_d = period_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    read_d    = 1'b0;
    timeout_d = 1'b0;
    overrun_d = 1'b0;
    capture   = 1'b0;
    abandon   = 1'b0;
    unique case (state_q)
      StWait: begin
        if (tick) begin
          read_d  = 1'b1;
          tmo_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        tmo_d     = tmo_q + 1'b1;
        overrun_d = tick;
        // A completion arriving on the timeout cycle still counts as a valid sample.
        if (i_valid) begin
          capture = 1'b1;
          state_d = StWait;
        end else if (tmo_q == TmoLast) begin
          abandon   = 1'b1;
          timeout_d = 1'b1;
          state_d   = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Debounce: a sample commits once it has been seen STABLE_POLLS times in a row.
  always_comb begin
    if (i_buttons == last_q) begin
      stable_inc = (stable_q >= StableMax) ? stable_q : stable_q + 1'b1;
    end else begin
      stable_inc = SW'(1);
    end

    stable_d   = stable_q;
    last_d     = last_q;
    buttons_d  = buttons_q;
    pressed_d  = '0;
    released_d = '0;
    update_d   = 1'b0;
    if (capture) begin
      stable_d = stable_inc;
      last_d   = i_buttons;
      if ((stable_inc >= StableMax) && (i_buttons != buttons_q)) begin
        buttons_d  = i_buttons;
        pressed_d  = i_buttons & ~buttons_q;
        released_d = ~i_buttons & buttons_q;
        update_d   = 1'b1;
      end
    end else if (abandon) begin
      stable_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= StWait;
      period_q   <= '0;
      tmo_q      <= '0;
      stable_q   <= '0;
      last_q     <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      read_q     <= 1'b0;
      update_q   <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      tmo_q      <= tmo_d;
      stable_q   <= stable_d;
      last_q     <= last_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      read_q     <= read_d;
      update_q   <= update_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign o_read_buttons = read_q;
  assign o_buttons      = buttons_q;
  assign o_pressed      = pressed_q;
  assign o_released     = released_q;
  assign o_update       = update_q;
  assign o_timeout      = timeout_q;
  assign o_overrun      = overrun_q;

endmodule
